ifu_fetch_ctrl: RTL and testbench

- Multi-cycle instruction fetch stage, directly upstream of the decode/execute datapath.
- Owns the PC register and issues one read per instruction on an AXI4-Lite-style read channel (AR/R).
- Presents the fetched instruction and its PC to the downstream datapath with a valid/ready handshake.
- Accepts the redirect (jump_en/jump_pc) that the datapath resolves when it retires the instruction.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_perf_cnt.sv | 28 ++
 rtl/ifu_fetch_ctrl.sv | 102 ++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } ifu_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [1:0]  RRESP_OKAY       = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Instruction fetches require word alignment; only the two LSBs matter.
  function automatic logic pc_aligned(input logic [1:0] pc_lsbs);
    return (pc_lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_perf_cnt.sv
// Fetch-unit performance counters: retired instructions and cycles spent
// waiting on the read channel. Both wrap modulo 2^32.
module ifu_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_i,
  input  logic        stall_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_i)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch stage: owns the PC, issues one AXI4-Lite read
// per instruction and hands it to the datapath. Define IFU_PERF_CNT_EN for perf counters.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  // read address channel
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  // read data channel
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  // datapath interface
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_pc,
  output logic            fetch_err
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  ifu_state_e      state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            err_q;

  logic pc_ok;
  assign pc_ok = pc_aligned(pc_q[1:0]);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          // A misaligned PC never reaches the bus; it retires as a faulting NOP.
          if (!pc_ok) begin
            inst_q  <= NOP_INST;
            err_q   <= 1'b1;
            state_q <= S_VALID;
          end else if (arready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rvalid) begin
            inst_q  <= rdata;
            err_q   <= (rresp != RRESP_OKAY);
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            pc_q    <= jump_en ? jump_pc : pc_q + XLEN'(4);
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  // Handshake strobes are state decodes, forced low for the whole reset cycle.
  assign arvalid    = !rst && (state_q == S_REQ) && pc_ok;
  assign rready     = !rst && (state_q == S_WAIT);
  assign inst_valid = !rst && (state_q == S_VALID);

  assign araddr    = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign fetch_err = err_q;

`ifdef IFU_PERF_CNT_EN
  ifu_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .retire_i    (inst_valid && inst_ready),
    .stall_i     (!rst && (state_q == S_REQ || state_q == S_WAIT)),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed self-checking bench for ifu_fetch_ctrl; perf counter checks are
// compiled in when IFU_PERF_CNT_EN is defined.
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        jump_en;
  logic [31:0] jump_pc;
  logic        fetch_err;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .inst       (inst),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .jump_en    (jump_en),
    .jump_pc    (jump_pc),
    .fetch_err  (fetch_err)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 3-cycle fetch: REQ (AR handshake), WAIT (R beat), VALID (retire).
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr,
                           input logic [31:0] word, input logic jmp,
                           input logic [31:0] target);
    check({tag, ".arvalid"}, {31'b0, arvalid}, 32'd1);
    check({tag, ".araddr"}, araddr, exp_addr);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = word;
    rresp   = 2'b00;
    tick();
    rvalid = 1'b0;
    check({tag, ".inst_valid"}, {31'b0, inst_valid}, 32'd1);
    check({tag, ".inst"}, inst, word);
    check({tag, ".pc"}, pc, exp_addr);
    inst_ready = 1'b1;
    jump_en    = jmp;
    jump_pc    = target;
    tick();
    inst_ready = 1'b0;
    jump_en    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    inst_ready = 1'b0; jump_en = 1'b0; jump_pc = '0;
    tick();
    tick();

    // Reset state
    check("rst.arvalid", {31'b0, arvalid}, 32'd0);
    check("rst.rready", {31'b0, rready}, 32'd0);
    check("rst.inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst.pc", pc, 32'h8000_0000);
    check("rst.inst", inst, 32'h0000_0013);
    check("rst.fetch_err", {31'b0, fetch_err}, 32'd0);
    rst = 1'b0;
    #1;

    // Basic fetch with minimum latency
    check("t1.arvalid", {31'b0, arvalid}, 32'd1);
    check("t1.araddr", araddr, 32'h8000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("t1.wait_rready", {31'b0, rready}, 32'd1);
    check("t1.wait_arvalid", {31'b0, arvalid}, 32'd0);
    check("t1.wait_inst_valid", {31'b0, inst_valid}, 32'd0);
    rvalid = 1'b1; rdata = 32'h0010_0093;
    tick();
    rvalid = 1'b0;
    check("t1.inst_valid", {31'b0, inst_valid}, 32'd1);
    check("t1.inst", inst, 32'h0010_0093);
    check("t1.pc", pc, 32'h8000_0000);
    check("t1.fetch_err", {31'b0, fetch_err}, 32'd0);
    check("t1.valid_rready", {31'b0, rready}, 32'd0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("t1.next_araddr", araddr, 32'h8000_0004);

    // arready stalled for 5 cycles; stray rvalid/inst_ready/jump_en are ignored
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    inst_ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h1234_5670;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2.stall_arvalid", {31'b0, arvalid}, 32'd1);
      check("t2.stall_araddr", araddr, 32'h8000_0004);
    end
    rvalid = 1'b0; inst_ready = 1'b0; jump_en = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("t2.one_hs_arvalid", {31'b0, arvalid}, 32'd0);
    check("t2.one_hs_rready", {31'b0, rready}, 32'd1);
    tick();
    check("t2.still_wait_arvalid", {31'b0, arvalid}, 32'd0);
    check("t2.still_wait_rready", {31'b0, rready}, 32'd1);
    rvalid = 1'b1; rdata = 32'h0020_0113;
    tick();
    rvalid = 1'b0;
    check("t2.inst", inst, 32'h0020_0113);
    check("t2.pc", pc, 32'h8000_0004);

    // Redirect at retire
    inst_ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h8000_0100;
    tick();
    inst_ready = 1'b0; jump_en = 1'b0;
    check("t3.jump_araddr", araddr, 32'h8000_0100);
    check("t3.jump_arvalid", {31'b0, arvalid}, 32'd1);

    // Bus error response, then redirect to a misaligned target
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    check("t4.err_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("t4.err_fetch_err", {31'b0, fetch_err}, 32'd1);
    inst_ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h8000_0102;
    tick();
    inst_ready = 1'b0; jump_en = 1'b0;
    check("t4.mis_arvalid", {31'b0, arvalid}, 32'd0);
    check("t4.mis_inst_valid", {31'b0, inst_valid}, 32'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("t4.mis_valid", {31'b0, inst_valid}, 32'd1);
    check("t4.mis_fetch_err", {31'b0, fetch_err}, 32'd1);
    check("t4.mis_inst", inst, 32'h0000_0013);
    check("t4.mis_pc", pc, 32'h8000_0102);
    inst_ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h8000_0200;
    tick();
    inst_ready = 1'b0; jump_en = 1'b0;
    check("t4.recover_araddr", araddr, 32'h8000_0200);
    check("t4.recover_arvalid", {31'b0, arvalid}, 32'd1);

    // Reset while waiting for data, with the beat arriving in the same cycle
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rst = 1'b1; rvalid = 1'b1; rdata = 32'h1111_1111;
    #1;
    check("t5.rst_rready", {31'b0, rready}, 32'd0);
    check("t5.rst_arvalid", {31'b0, arvalid}, 32'd0);
    tick();
    rst = 1'b0; rvalid = 1'b0;
    #1;
    check("t5.after_arvalid", {31'b0, arvalid}, 32'd1);
    check("t5.after_pc", pc, 32'h8000_0000);
    check("t5.after_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("t5.after_inst", inst, 32'h0000_0013);
    check("t5.after_fetch_err", {31'b0, fetch_err}, 32'd0);

    // Four back-to-back fetches, including PC wrap at the top of memory
    fetch_one("t6.f0", 32'h8000_0000, 32'h0000_0093, 1'b1, 32'hFFFF_FFFC);
    fetch_one("t6.f1", 32'hFFFF_FFFC, 32'h0000_0113, 1'b0, 32'h0);
    fetch_one("t6.f2", 32'h0000_0000, 32'h0000_0193, 1'b0, 32'h0);
    fetch_one("t6.f3", 32'h0000_0004, 32'h0000_0213, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    check("t6.perf_fetch_cnt", perf_fetch_cnt, 32'd4);
    check("t6.perf_stall_cnt", perf_stall_cnt, 32'd8);
`endif
    check("t6.final_araddr", araddr, 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
